// File: rtl/dest_sel_pipe.sv
// rtl/dest_sel_pipe.sv - destination register select with DEPTH-stage valid pipeline and RAW hazard detect
module dest_sel_pipe #(
  parameter int              AW       = 4,
  parameter int              DEPTH    = 3,
  parameter logic [AW-1:0]   LINK_REG = AW'(4'b1111),
  parameter logic [AW-1:0]   ALT_REG  = AW'(4'b1110)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [2:0]    sel,
  input  logic [AW-1:0] data0,
  input  logic [AW-1:0] data2,
  input  logic [AW-1:0] data4,
  input  logic [AW-1:0] data5,
  input  logic          stall,
  input  logic          flush,
  input  logic [AW-1:0] src_a,
  input  logic [AW-1:0] src_b,
  output logic [AW-1:0] wb_addr,
  output logic          wb_valid,
  output logic          hazard_a,
  output logic          hazard_b,
  output logic [3:0]    occupancy,
  output logic          sel_err
);

  // Stage 0 is the capture stage, stage DEPTH-1 is writeback.
  logic [DEPTH-1:0][AW-1:0] addr_q, addr_d;
  logic [DEPTH-1:0]         v_q, v_d;
  logic                     sel_err_q, sel_err_d;
  logic [AW-1:0]            mux_addr;
  logic                     sel_ok;

  // Destination mux; unused select codes yield address 0 and an invalid entry.
  always_comb begin
    mux_addr = '0;
    case (sel)
      3'd0:    mux_addr = data0;
      3'd1:    mux_addr = LINK_REG;
      3'd2:    mux_addr = data2;
      3'd3:    mux_addr = ALT_REG;
      3'd4:    mux_addr = data4;
      3'd5:    mux_addr = data5;
      default: mux_addr = '0;
    endcase
    sel_ok = (sel <= 3'd5);
  end

  // Next-state: flush clears every valid bit, stall freezes, otherwise shift and capture.
  always_comb begin
    addr_d    = addr_q;
    v_d       = v_q;
    sel_err_d = in_valid && !sel_ok && !stall;
    if (flush) begin
      v_d = '0;
    end else if (!stall) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        addr_d[k] = addr_q[k-1];
        v_d[k]    = v_q[k-1];
      end
      addr_d[0] = mux_addr;
      v_d[0]    = in_valid && sel_ok;
    end
  end

  // State registers with synchronous reset that overrides stall and flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      v_q       <= '0;
      sel_err_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      v_q       <= v_d;
      sel_err_q <= sel_err_d;
    end
  end

  // Hazards include the writeback stage since the register file updates at the edge.
  always_comb begin
    hazard_a  = 1'b0;
    hazard_b  = 1'b0;
    occupancy = 4'd0;
    for (int k = 0; k < DEPTH; k++) begin
      if (v_q[k] && (addr_q[k] == src_a)) hazard_a = 1'b1;
      if (v_q[k] && (addr_q[k] == src_b)) hazard_b = 1'b1;
      occupancy = occupancy + {3'b000, v_q[k]};
    end
  end

  // A stalled writeback entry is held, so suppress its write unless a flush forces the commit.
  assign wb_addr  = addr_q[DEPTH-1];
  assign wb_valid = v_q[DEPTH-1] && (flush || !stall);
  assign sel_err  = sel_err_q;

endmodule

// File: tb/tb_dest_sel_pipe.sv
// tb/tb_dest_sel_pipe.sv - self-checking bench for dest_sel_pipe against a queue-based reference
module tb_dest_sel_pipe;
  localparam int AW    = 4;
  localparam int DEPTH = 3;

  logic          clk = 1'b0;
  logic          reset, in_valid, stall, flush;
  logic [2:0]    sel;
  logic [AW-1:0] data0, data2, data4, data5, src_a, src_b;
  logic [AW-1:0] wb_addr;
  logic          wb_valid, hazard_a, hazard_b, sel_err;
  logic [3:0]    occupancy;

  always #5 clk = ~clk;

  dest_sel_pipe #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sel(sel),
    .data0(data0), .data2(data2), .data4(data4), .data5(data5),
    .stall(stall), .flush(flush), .src_a(src_a), .src_b(src_b),
    .wb_addr(wb_addr), .wb_valid(wb_valid), .hazard_a(hazard_a),
    .hazard_b(hazard_b), .occupancy(occupancy), .sel_err(sel_err)
  );

  // sure=0 marks an address left stale by a flush, which is not significant.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic          v;
    logic          sure;
  } ent_t;

  ent_t          pipe[$];
  logic          sel_err_exp;
  bit            known;
  int            errors;
  int            checks;
  logic [AW-1:0] wb_log[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] ref_dest(input logic [2:0] s);
    logic [AW-1:0] tab[8];
    tab = '{data0, 4'hF, data2, 4'hE, data4, data5, 4'h0, 4'h0};
    return tab[s];
  endfunction

  task automatic cycle(input logic iv, input logic [2:0] s, input logic st, input logic fl,
                       input logic rs, input logic [AW-1:0] sa, input logic [AW-1:0] sb);
    ent_t       wb;
    logic       e_ha, e_hb;
    logic [3:0] e_occ;
    in_valid = iv; sel = s; stall = st; flush = fl; reset = rs; src_a = sa; src_b = sb;
    @(negedge clk);
    if (known) begin
      wb = pipe[DEPTH-1];
      e_ha = 1'b0; e_hb = 1'b0; e_occ = 4'd0;
      foreach (pipe[k]) begin
        if (pipe[k].v && pipe[k].addr == sa) e_ha = 1'b1;
        if (pipe[k].v && pipe[k].addr == sb) e_hb = 1'b1;
        if (pipe[k].v) e_occ++;
      end
      chk("wb_valid", {7'd0, wb_valid}, {7'd0, wb.v && (fl || !st)});
      if (wb.sure || wb.v) chk("wb_addr", {4'd0, wb_addr}, {4'd0, wb.addr});
      chk("hazard_a", {7'd0, hazard_a}, {7'd0, e_ha});
      chk("hazard_b", {7'd0, hazard_b}, {7'd0, e_hb});
      chk("occupancy", {4'd0, occupancy}, {4'd0, e_occ});
      chk("sel_err", {7'd0, sel_err}, {7'd0, sel_err_exp});
    end
    if (wb_valid === 1'b1) wb_log.push_back(wb_addr);
    @(posedge clk);
    if (rs) begin
      pipe.delete();
      repeat (DEPTH) pipe.push_back(ent_t'{addr: '0, v: 1'b0, sure: 1'b1});
      sel_err_exp = 1'b0;
      known = 1'b1;
    end else if (fl) begin
      foreach (pipe[k]) begin
        pipe[k].v    = 1'b0;
        pipe[k].sure = 1'b0;
      end
      sel_err_exp = iv && (s >= 3'd6) && !st;
    end else if (!st) begin
      pipe.push_front(ent_t'{addr: ref_dest(s), v: iv && (s <= 3'd5), sure: 1'b1});
      void'(pipe.pop_back());
      sel_err_exp = iv && (s >= 3'd6);
    end else begin
      sel_err_exp = 1'b0;
    end
    #1;
  endtask

  initial begin
    logic [AW-1:0] seq_exp[6];
    errors = 0; checks = 0; known = 1'b0; sel_err_exp = 1'b0;
    data0 = '0; data2 = '0; data4 = '0; data5 = '0;
    in_valid = 0; sel = 0; stall = 0; flush = 0; reset = 1; src_a = 0; src_b = 0;

    // Reset, then reset state
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // All six legal selects back to back
    data0 = 3; data2 = 5; data4 = 7; data5 = 9;
    wb_log.delete();
    for (int s = 0; s < 6; s++) cycle(1, 3'(s), 0, 0, 0, 4'd1, 4'd2);
    repeat (3) cycle(0, 0, 0, 0, 0, 4'd1, 4'd2);
    seq_exp = '{4'd3, 4'd15, 4'd5, 4'd14, 4'd7, 4'd9};
    chk("wb_seq_len", 8'(wb_log.size()), 8'd6);
    for (int i = 0; i < 6; i++)
      if (i < wb_log.size()) chk("wb_seq", {4'd0, wb_log[i]}, {4'd0, seq_exp[i]});

    // Illegal selects raise sel_err and leave invalid slots
    cycle(1, 6, 0, 0, 0, 0, 0);
    cycle(1, 7, 0, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0);

    // Stall holding an entry at writeback
    data0 = 4;
    wb_log.delete();
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 4, 0);
    cycle(1, 0, 1, 0, 0, 4, 0);
    cycle(0, 0, 0, 0, 0, 4, 0);
    cycle(0, 0, 0, 0, 0, 4, 0);
    chk("stall_single_commit", 8'(wb_log.size()), 8'd1);

    // Flush with pipe holding 2,6,8 (oldest 8); input during flush is dropped
    data0 = 8; cycle(1, 0, 0, 0, 0, 0, 0);
    data0 = 6; cycle(1, 0, 0, 0, 0, 0, 0);
    data0 = 2; cycle(1, 0, 0, 0, 0, 0, 0);
    data0 = 11; cycle(1, 0, 0, 1, 0, 11, 8);
    repeat (3) cycle(0, 0, 0, 0, 0, 11, 2);

    // Hazards: 6 in flight, link register absent
    data0 = 6; cycle(1, 0, 0, 0, 0, 6, 15);
    cycle(0, 0, 0, 0, 0, 6, 15);
    cycle(0, 0, 0, 0, 0, 6, 15);
    cycle(0, 0, 0, 0, 0, 6, 15);
    cycle(0, 0, 0, 0, 0, 6, 15);

    // Reset overrides stall and flush with a full pipe, then a fresh entry
    data0 = 1; data5 = 10;
    repeat (3) cycle(1, 0, 0, 0, 0, 1, 1);
    cycle(1, 0, 1, 1, 1, 1, 1);
    cycle(1, 5, 0, 0, 0, 10, 1);
    repeat (3) cycle(0, 0, 0, 0, 0, 10, 1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      data0 = 4'($urandom); data2 = 4'($urandom); data4 = 4'($urandom); data5 = 4'($urandom);
      cycle(($urandom_range(3, 0) != 0), 3'($urandom), ($urandom_range(3, 0) == 0),
            ($urandom_range(9, 0) == 0), ($urandom_range(39, 0) == 0),
            4'($urandom), ($urandom_range(1, 0) == 0) ? data0 : 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
